// File: rtl/sr_latch_bist.sv
// Built-in self-test engine for a gated SR latch: drives a fixed five-step
// S/R/enable sequence, checks Q/Q_bar at the end of each step, reports results.
module sr_latch_bist #(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       Q_in,
    input  logic       Q_bar_in,
    output logic       S_out,
    output logic       R_out,
    output logic       enable_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_step,
    output logic [7:0] err_count
);

    localparam int            CW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [2:0]    LAST_STEP = 3'd4;
    localparam logic [2:0]    NO_FAIL   = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [2:0]    step;
    logic [CW-1:0] cyc;

    // {S, R, enable} applied during each step
    function automatic logic [2:0] drive_vec(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b101;
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            3'd3:    return 3'b100;
            3'd4:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // {Q, Q_bar} expected at the end of each step
    function automatic logic [1:0] expect_vec(input logic [2:0] idx);
        case (idx)
            3'd0:    return 2'b10;
            3'd1:    return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    logic [1:0] cur_exp;
    logic [2:0] nxt_drive;
    logic       step_end;
    logic       step_fail;
    logic [7:0] count_next;
    logic [2:0] first_next;

    always_comb begin
        cur_exp    = expect_vec(step);
        nxt_drive  = drive_vec(step + 3'd1);
        step_end   = (state == RUN) && (cyc == CYC_LAST);
        step_fail  = step_end && ((Q_in != cur_exp[1]) || (Q_bar_in != cur_exp[0]));
        count_next = step_fail ? sat_inc(err_count) : err_count;
        first_next = (step_fail && (err_step == NO_FAIL)) ? step : err_step;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            step       <= 3'd0;
            cyc        <= '0;
            S_out      <= 1'b0;
            R_out      <= 1'b0;
            enable_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_step   <= NO_FAIL;
            err_count  <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state                          <= RUN;
                        step                           <= 3'd0;
                        cyc                            <= '0;
                        {S_out, R_out, enable_out}     <= drive_vec(3'd0);
                        busy                           <= 1'b1;
                        done                           <= 1'b0;
                        pass                           <= 1'b0;
                        err_step                       <= NO_FAIL;
                        err_count                      <= 8'd0;
                    end
                end
                RUN: begin
                    err_count <= count_next;
                    err_step  <= first_next;
                    if (step_end) begin
                        cyc <= '0;
                        if (step == LAST_STEP) begin
                            // Final compare lands on the same edge that publishes the result
                            state                      <= DONE;
                            {S_out, R_out, enable_out} <= 3'b000;
                            busy                       <= 1'b0;
                            done                       <= 1'b1;
                            pass                       <= (count_next == 8'd0);
                        end else begin
                            step                       <= step + 3'd1;
                            {S_out, R_out, enable_out} <= nxt_drive;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_bist.sv
// Directed bench for sr_latch_bist: a behavioural gated SR latch with
// selectable faults sits under the BIST, and results are checked by hand values.
module tb_sr_latch_bist;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       Q_in;
    logic       Q_bar_in;
    logic       S_out;
    logic       R_out;
    logic       enable_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_step;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    // 0 = good latch, 1 = Q stuck at 0, 2 = enable ignored, 3 = Q_bar tied to Q
    int   mode = 0;
    logic lq   = 1'b0;

    logic [2:0] exp_drive [5] = '{3'b101, 3'b001, 3'b011, 3'b100, 3'b001};

    sr_latch_bist #(.STEP_CYCLES(SC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .Q_in       (Q_in),
        .Q_bar_in   (Q_bar_in),
        .S_out      (S_out),
        .R_out      (R_out),
        .enable_out (enable_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_step   (err_step),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Latch settles half a cycle after the registered drives change
    always @(negedge clk) begin
        if (enable_out || mode == 2) begin
            if (S_out)      lq <= 1'b1;
            else if (R_out) lq <= 1'b0;
        end
    end

    always_comb begin
        Q_in     = lq;
        Q_bar_in = ~lq;
        case (mode)
            1: begin Q_in = 1'b0; Q_bar_in = 1'b1; end
            3: begin Q_in = lq;   Q_bar_in = lq;   end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_sre"},   {29'd0, S_out, R_out, enable_out}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy},  32'd0);
        chk({tag, "_done"},  {31'd0, done},  32'd0);
        chk({tag, "_pass"},  {31'd0, pass},  32'd0);
        chk({tag, "_estep"}, {29'd0, err_step},  32'd7);
        chk({tag, "_ecnt"},  {24'd0, err_count}, 32'd0);
    endtask

    task automatic run_test(input string tag, input int m, input int ecnt,
                            input int estep, input bit repulse);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_drv%0d", tag, k), {29'd0, S_out, R_out, enable_out},
                {29'd0, exp_drive[k]});
            if (k == 0) chk({tag, "_done0"}, {31'd0, done}, 32'd0);
            for (int c = 0; c < SC; c++) begin
                if (repulse && k == 1 && c == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_end_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_end_pass"}, {31'd0, pass}, (ecnt == 0) ? 32'd1 : 32'd0);
        chk({tag, "_end_ecnt"}, {24'd0, err_count}, ecnt);
        chk({tag, "_end_estep"}, {29'd0, err_step}, estep);
        chk({tag, "_end_sre"}, {29'd0, S_out, R_out, enable_out}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        chk_reset_values("rst");
        reset = 1'b0;
        repeat (3) tick();
        chk_reset_values("idle");

        // Good latch; start re-pulsed mid-run must be ignored
        run_test("good", 0, 0, 7, 1'b1);
        run_test("stuck", 1, 2, 0, 1'b0);

        // Restart from DONE clears results on the next edge
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_done",  {31'd0, done}, 32'd0);
        chk("restart_busy",  {31'd0, busy}, 32'd1);
        chk("restart_ecnt",  {24'd0, err_count}, 32'd0);
        chk("restart_estep", {29'd0, err_step}, 32'd7);
        chk("restart_pass",  {31'd0, pass}, 32'd0);
        repeat (5 * SC) tick();
        chk("restart_end_done", {31'd0, done}, 32'd1);
        chk("restart_end_pass", {31'd0, pass}, 32'd1);

        run_test("noen", 2, 2, 3, 1'b0);
        run_test("tied", 3, 5, 0, 1'b0);

        // Reset in the middle of a run
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk_reset_values("midrst");
        start = 1'b1;
        tick();
        chk("rst_wins_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        run_test("clean", 0, 0, 7, 1'b0);

        // Start held high: back-to-back runs with a single DONE cycle between
        start = 1'b1;
        tick();
        repeat (5 * SC) tick();
        chk("b2b_done", {31'd0, done}, 32'd1);
        tick();
        chk("b2b_rerun_busy", {31'd0, busy}, 32'd1);
        chk("b2b_rerun_done", {31'd0, done}, 32'd0);
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
